relogio_monitor: RTL and testbench
==================================

Name: relogio_monitor

Overview:
- Reads the clock's display interface (four 7-segment digit buses, 7-bit seconds LEDs, 2-bit mode LEDs) and decodes it back to BCD time.
- Checks that time advances legally in run mode and flags invalid segment patterns and illegal jumps.
- Used as an on-chip self-check and as a bench scoreboard front-end next to the clock.

Parameters:
- LOCK_CNT, 4, number of consecutive legal samples needed to enter LOCKED.
- ERR_W, 8, width of the saturating error counter.
- STALL_MAX, 16, run-mode cycles with an unchanged sample before a stall error (only with MON_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- disp0  in  7  minute-units digit segments, {a,b,c,d,e,f,g}, active-high
- disp1  in  7  minute-tens digit segments
- disp2  in  7  hour-units digit segments
- disp3  in  7  hour-tens digit segments
- sec_led  in  7  seconds, binary
- mode_led  in  2  00 run, 01 set-minute, 10 set-hour, 11 illegal
- hh_bcd  out  8  decoded hours {tens,units}
- mm_bcd  out  8  decoded minutes {tens,units}
- ss_bin  out  7  seconds
- sample_valid  out  1  last sample decoded to a legal time
- locked  out  1  mon_state == LOCKED
- err_pulse  out  1  one-cycle error strobe
- err_count  out  ERR_W  saturating error total
- mon_state  out  2  00 UNLOCKED, 01 LOCKED, 10 FAULT

Behaviour:
- Segment decode table (0..9 only): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other pattern, including A–F glyphs, is invalid.
- Legal time: hour ≤ 23, minute tens ≤ 5, sec_led ≤ 59. sample_valid = all digits decodable AND legal.
- Pipeline stage 1: register all inputs at edge N.
- Pipeline stage 2: decode, compare and update outputs at edge N+1. Total latency is 2 cycles.
- prev: the last valid sample, held internally.
- Successor: ss+1; at 59 → 0 with a minute carry; 59 min → 0 with an hour carry; 23:59:59 → 00:00:00.
- Legal step: cur == succ(prev) or cur == prev (hold).
- mode_led != 00 (set modes, and illegal 11):
  - Force UNLOCKED, clear the match counter, no checking, no errors.
  - Decoded outputs keep tracking the inputs.
- UNLOCKED, run mode:
  - Valid sample → prev := cur, match counter +1 (the first sample counts as 1).
  - Non-successor valid sample → counter := 1.
  - Invalid sample → counter := 0, no error.
  - Counter reaches LOCK_CNT → LOCKED.
- LOCKED:
  - Illegal step or invalid sample → err_pulse=1 for one cycle, err_count +1 (saturates at all-ones), go to FAULT.
  - Legal step → prev := cur.
- FAULT:
  - Same counting rule as UNLOCKED, but errors are still reported on every illegal or invalid sample.
  - LOCK_CNT consecutive legal steps → LOCKED.
  - prev updates on every valid sample.
- Simultaneous mode change and error in the same sample: mode wins; no error is reported.
- Reset (asynchronous, any time):
  - mon_state=UNLOCKED, locked=0, err_pulse=0, err_count=0.
  - hh_bcd=mm_bcd=0, ss_bin=0, sample_valid=0.
  - Pipeline registers, prev and counters cleared.
  - The first post-reset output appears 2 edges after rst deasserts.
- err_count does not clear except by rst.

Optional Feature:
- Macro MON_WATCHDOG_EN.
- Defined:
  - In LOCKED, count consecutive run-mode samples with cur == prev.
  - At STALL_MAX: err_pulse, err_count+1, go to FAULT, reset the stall counter.
  - The stall counter clears on any changed sample or non-run mode.
- Undefined: holds are always legal; no stall counter logic is present.

Test Plan:
- Reset then run samples 12:34:56, 12:34:57, 12:34:58, 12:34:59 (disp3=0110000, disp2=1101101, disp1=1111001, disp0=0110011) → locked=1 two cycles after the 4th sample; err_count=0; hh_bcd=8'h12, mm_bcd=8'h34.
- While locked, feed 23:59:59 then 00:00:00 → no error; then 00:00:05 → err_pulse once, err_count=1, mon_state=FAULT.
- Set disp0=1110111 ("A") while LOCKED → sample_valid=0, err_pulse=1, FAULT; 4 further legal steps → LOCKED.
- Switch mode_led to 01 and change minutes arbitrarily (jump 05 → 41) → no error, mon_state=UNLOCKED; return to 00 → relock after 4 legal samples.
- Force 2^ERR_W+3 errors → err_count saturates at 8'hFF; assert rst mid-stream → all outputs return to 0 asynchronously.
- With MON_WATCHDOG_EN: hold 08:15:30 for 16 samples while LOCKED → one err_pulse, FAULT. Without the macro → no error.

Source files
------------

// File: rtl/relogio_monitor.sv
// relogio_monitor: decodes the clock display (7-seg digits, seconds LEDs,
// mode LEDs) back to BCD time and checks that run-mode time advances legally.
// Two-stage pipeline: stage 1 registers the raw display, stage 2 decodes,
// compares against the previous valid sample and updates all outputs.
// Optional macro MON_WATCHDOG_EN adds a stall watchdog (STALL_MAX holds while
// LOCKED raise an error); without it holds are always legal.
module relogio_monitor #(
   parameter int unsigned LOCK_CNT  = 4,
   parameter int unsigned ERR_W     = 8
`ifdef MON_WATCHDOG_EN
   ,parameter int unsigned STALL_MAX = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       disp0,
   input  logic [6:0]       disp1,
   input  logic [6:0]       disp2,
   input  logic [6:0]       disp3,
   input  logic [6:0]       sec_led,
   input  logic [1:0]       mode_led,
   output logic [7:0]       hh_bcd,
   output logic [7:0]       mm_bcd,
   output logic [6:0]       ss_bin,
   output logic             sample_valid,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       mon_state
);

   localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_LOCKED   = 2'b01,
      ST_FAULT    = 2'b10
   } mon_state_e;

   // Returns {valid, digit}; only the ten numeric glyphs are accepted.
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b1111110: r = {1'b1, 4'd0};
         7'b0110000: r = {1'b1, 4'd1};
         7'b1101101: r = {1'b1, 4'd2};
         7'b1111001: r = {1'b1, 4'd3};
         7'b0110011: r = {1'b1, 4'd4};
         7'b1011011: r = {1'b1, 4'd5};
         7'b1011111: r = {1'b1, 4'd6};
         7'b1110000: r = {1'b1, 4'd7};
         7'b1111111: r = {1'b1, 4'd8};
         7'b1111011: r = {1'b1, 4'd9};
         default:    r = '0;
      endcase
      return r;
   endfunction

   // ---------------- stage 1: raw display capture ----------------
   logic [6:0] d0_q, d1_q, d2_q, d3_q, sec_q;
   logic [6:0] d0_d, d1_d, d2_d, d3_d, sec_d;
   logic [1:0] mode_q, mode_d;

   // Stage-1 next values are the raw inputs.
   always_comb begin
      d0_d   = disp0;
      d1_d   = disp1;
      d2_d   = disp2;
      d3_d   = disp3;
      sec_d  = sec_led;
      mode_d = mode_led;
   end

   // Stage-1 registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0_q   <= '0;
         d1_q   <= '0;
         d2_q   <= '0;
         d3_q   <= '0;
         sec_q  <= '0;
         mode_q <= '0;
      end else begin
         d0_q   <= d0_d;
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         d3_q   <= d3_d;
         sec_q  <= sec_d;
         mode_q <= mode_d;
      end
   end

   // ---------------- stage 2: decode and check ----------------
   logic [4:0]  dec0, dec1, dec2, dec3;
   logic [3:0]  h_t, h_u, m_t, m_u;
   logic        all_dec, legal_time, cur_valid;
   logic [22:0] cur_vec, succ_vec;
   logic        is_hold, is_succ, legal_step;

   assign dec0 = seg_dec(d0_q);
   assign dec1 = seg_dec(d1_q);
   assign dec2 = seg_dec(d2_q);
   assign dec3 = seg_dec(d3_q);
   assign h_t  = dec3[3:0];
   assign h_u  = dec2[3:0];
   assign m_t  = dec1[3:0];
   assign m_u  = dec0[3:0];

   assign all_dec    = dec0[4] & dec1[4] & dec2[4] & dec3[4];
   assign legal_time = ((h_t < 4'd2) || ((h_t == 4'd2) && (h_u <= 4'd3))) &&
                       (m_t <= 4'd5) && (sec_q <= 7'd59);
   assign cur_valid  = all_dec & legal_time;
   assign cur_vec    = {h_t, h_u, m_t, m_u, sec_q};

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [22:0]      prev_q, prev_d;
   logic [7:0]       hh_q, hh_d, mm_q, mm_d;
   logic [6:0]       ss_q, ss_d;
   logic             valid_q, valid_d, err_q, err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
`ifdef MON_WATCHDOG_EN
   localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
`endif

   // One-second successor of the previous valid sample, with carries.
   always_comb begin
      logic [3:0] s_ht, s_hu, s_mt, s_mu;
      logic [6:0] s_ss;
      s_ht = prev_q[22:19];
      s_hu = prev_q[18:15];
      s_mt = prev_q[14:11];
      s_mu = prev_q[10:7];
      s_ss = prev_q[6:0];
      if (s_ss == 7'd59) begin
         s_ss = '0;
         if (s_mu == 4'd9) begin
            s_mu = '0;
            if (s_mt == 4'd5) begin
               s_mt = '0;
               if ((s_ht == 4'd2) && (s_hu == 4'd3)) begin
                  s_ht = '0;
                  s_hu = '0;
               end else if (s_hu == 4'd9) begin
                  s_hu = '0;
                  s_ht = s_ht + 4'd1;
               end else begin
                  s_hu = s_hu + 4'd1;
               end
            end else begin
               s_mt = s_mt + 4'd1;
            end
         end else begin
            s_mu = s_mu + 4'd1;
         end
      end else begin
         s_ss = s_ss + 7'd1;
      end
      succ_vec = {s_ht, s_hu, s_mt, s_mu, s_ss};
   end

   assign is_hold    = (cur_vec == prev_q);
   assign is_succ    = (cur_vec == succ_vec);
   assign legal_step = is_hold | is_succ;
   assign cnt_inc    = legal_step ? (cnt_q + CNT_W'(1)) : CNT_W'(1);

   // Monitor state machine: lock tracking, error detection, output update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prev_d      = prev_q;
      err_d       = 1'b0;
      hh_d        = {h_t, h_u};
      mm_d        = {m_t, m_u};
      ss_d        = sec_q;
      valid_d     = cur_valid;
`ifdef MON_WATCHDOG_EN
      stall_d     = '0;
`endif
      if (mode_q != 2'b00) begin
         // Set modes (and the illegal 11) suppress all checking.
         state_d = ST_UNLOCKED;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_UNLOCKED, ST_FAULT: begin
               if (!cur_valid) begin
                  cnt_d = '0;
                  err_d = (state_q == ST_FAULT);
               end else begin
                  prev_d = cur_vec;
                  if (!legal_step && (state_q == ST_FAULT)) err_d = 1'b1;
                  if (cnt_inc == CNT_W'(LOCK_CNT)) begin
                     state_d = ST_LOCKED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            ST_LOCKED: begin
               if (!cur_valid) begin
                  err_d   = 1'b1;
                  state_d = ST_FAULT;
                  cnt_d   = '0;
               end else if (!legal_step) begin
                  // The offending sample becomes the new reference so that
                  // recovery counts from it rather than re-flagging forever.
                  err_d   = 1'b1;
                  state_d = ST_FAULT;
                  prev_d  = cur_vec;
                  cnt_d   = CNT_W'(1);
               end else begin
                  prev_d = cur_vec;
`ifdef MON_WATCHDOG_EN
                  if (is_hold) begin
                     if (stall_q == STALL_W'(STALL_MAX - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                     end else begin
                        stall_d = stall_q + STALL_W'(1);
                     end
                  end
`endif
               end
            end
            default: begin
               state_d = ST_UNLOCKED;
               cnt_d   = '0;
            end
         endcase
      end
      err_count_d = err_count_q;
      if (err_d && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
   end

   // Stage-2 registers: monitor state and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_UNLOCKED;
         cnt_q       <= '0;
         prev_q      <= '0;
         hh_q        <= '0;
         mm_q        <= '0;
         ss_q        <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
`ifdef MON_WATCHDOG_EN
         stall_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_q      <= prev_d;
         hh_q        <= hh_d;
         mm_q        <= mm_d;
         ss_q        <= ss_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
`ifdef MON_WATCHDOG_EN
         stall_q     <= stall_d;
`endif
      end
   end

   assign hh_bcd       = hh_q;
   assign mm_bcd       = mm_q;
   assign ss_bin       = ss_q;
   assign sample_valid = valid_q;
   assign locked       = (state_q == ST_LOCKED);
   assign err_pulse    = err_q;
   assign err_count    = err_count_q;
   assign mon_state    = state_q;

endmodule

// File: tb/tb_relogio_monitor.sv
// Directed testbench for relogio_monitor. Each drive call presents one sample
// and returns 1 time unit after the capturing edge; the outputs visible then
// belong to the previously driven sample (2-cycle latency).
module tb_relogio_monitor;

   logic       clk, rst;
   logic [6:0] disp0, disp1, disp2, disp3, sec_led;
   logic [1:0] mode_led;
   logic [7:0] hh_bcd, mm_bcd, err_count;
   logic [6:0] ss_bin;
   logic       sample_valid, locked, err_pulse;
   logic [1:0] mon_state;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

`ifdef MON_WATCHDOG_EN
   localparam int WD_ERRS = 1;
`else
   localparam int WD_ERRS = 0;
`endif

   relogio_monitor #(
      .LOCK_CNT (4),
      .ERR_W    (8)
`ifdef MON_WATCHDOG_EN
      ,.STALL_MAX(16)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
      .sec_led(sec_led), .mode_led(mode_led),
      .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bin(ss_bin),
      .sample_valid(sample_valid), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .mon_state(mon_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (err_pulse === 1'b1) pulses++;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic drive_raw(input logic [6:0] d3, d2, d1, d0, s, input logic [1:0] md);
      disp3 = d3; disp2 = d2; disp1 = d1; disp0 = d0; sec_led = s; mode_led = md;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int hh, mm, ss, input logic [1:0] md);
      drive_raw(seg7(hh / 10), seg7(hh % 10), seg7(mm / 10), seg7(mm % 10), 7'(ss), md);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      disp0 = '0; disp1 = '0; disp2 = '0; disp3 = '0; sec_led = '0; mode_led = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (hh_bcd !== 8'h00) begin fails++; $display("FAIL reset_hh: got %h want 00", hh_bcd); end
      tests++; if (mm_bcd !== 8'h00) begin fails++; $display("FAIL reset_mm: got %h want 00", mm_bcd); end
      tests++; if (ss_bin !== 7'd0) begin fails++; $display("FAIL reset_ss: got %0d want 0", ss_bin); end
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
      tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL reset_err_count: got %h want 00", err_count); end
      tests++; if (mon_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", mon_state); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lock;
      drive(12, 34, 56, 2'b00);
      drive(12, 34, 57, 2'b00);
      drive(12, 34, 58, 2'b00);
      drive(12, 34, 59, 2'b00);
      // outputs now show 12:34:58 (three matches so far)
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %b want 0", locked); end
      tests++; if (ss_bin !== 7'd58) begin fails++; $display("FAIL lock_ss58: got %0d want 58", ss_bin); end
      drive(12, 35, 0, 2'b00);
      // outputs now show 12:34:59
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_locked: got %b want 1", locked); end
      tests++; if (mon_state !== 2'b01) begin fails++; $display("FAIL lock_state: got %b want 01", mon_state); end
      tests++; if (hh_bcd !== 8'h12) begin fails++; $display("FAIL lock_hh: got %h want 12", hh_bcd); end
      tests++; if (mm_bcd !== 8'h34) begin fails++; $display("FAIL lock_mm: got %h want 34", mm_bcd); end
      tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL lock_valid: got %b want 1", sample_valid); end
      tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL lock_err_count: got %h want 00", err_count); end
   endtask

   task automatic test_wrap_and_jump;
      drive(23, 59, 55, 2'b10);
      drive(23, 59, 56, 2'b00);
      drive(23, 59, 57, 2'b00);
      drive(23, 59, 58, 2'b00);
      drive(23, 59, 59, 2'b00);
      drive(0, 0, 0, 2'b00);
      // outputs: 23:59:59, fourth consecutive legal sample
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked: got %b want 1", locked); end
      tests++; if (hh_bcd !== 8'h23) begin fails++; $display("FAIL wrap_hh: got %h want 23", hh_bcd); end
      drive(0, 0, 5, 2'b00);
      // outputs: 00:00:00 after midnight wrap
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL wrap_no_err: got %b want 0", err_pulse); end
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_still_locked: got %b want 1", locked); end
      tests++; if ({hh_bcd, mm_bcd} !== 16'h0000) begin fails++; $display("FAIL wrap_hhmm: got %h want 0000", {hh_bcd, mm_bcd}); end
      drive(0, 0, 6, 2'b00);
      // outputs: 00:00:05, an illegal jump
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL jump_err_pulse: got %b want 1", err_pulse); end
      tests++; if (err_count !== 8'h01) begin fails++; $display("FAIL jump_err_count: got %h want 01", err_count); end
      tests++; if (mon_state !== 2'b10) begin fails++; $display("FAIL jump_state: got %b want 10", mon_state); end
      drive(0, 0, 7, 2'b00);
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL jump_pulse_width: got %b want 0", err_pulse); end
      tests++; if (mon_state !== 2'b10) begin fails++; $display("FAIL jump_state_hold: got %b want 10", mon_state); end
      drive(0, 0, 8, 2'b00);
      drive(0, 0, 9, 2'b00);
      // outputs: 00:00:08, fourth legal step since the jump
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL jump_relock: got %b want 1", locked); end
   endtask

   task automatic test_invalid_glyph;
      drive_raw(seg7(0), seg7(0), seg7(0), 7'b1110111, 7'd10, 2'b00);
      drive(0, 0, 10, 2'b00);
      // outputs: the sample carrying an "A" glyph
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL glyph_valid: got %b want 0", sample_valid); end
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL glyph_err_pulse: got %b want 1", err_pulse); end
      tests++; if (err_count !== 8'h02) begin fails++; $display("FAIL glyph_err_count: got %h want 02", err_count); end
      tests++; if (mon_state !== 2'b10) begin fails++; $display("FAIL glyph_state: got %b want 10", mon_state); end
      drive(0, 0, 11, 2'b00);
      drive(0, 0, 12, 2'b00);
      drive(0, 0, 13, 2'b00);
      // outputs: 00:00:12, third legal step
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL glyph_not_yet: got %b want 0", locked); end
      drive(0, 0, 14, 2'b00);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL glyph_relock: got %b want 1", locked); end
      tests++; if (err_count !== 8'h02) begin fails++; $display("FAIL glyph_count_hold: got %h want 02", err_count); end
   endtask

   task automatic test_set_mode;
      drive(0, 5, 20, 2'b01);
      drive(0, 41, 20, 2'b01);
      // outputs: 00:05:20 in set-minute mode
      tests++; if (mon_state !== 2'b00) begin fails++; $display("FAIL set_state: got %b want 00", mon_state); end
      tests++; if (mm_bcd !== 8'h05) begin fails++; $display("FAIL set_mm05: got %h want 05", mm_bcd); end
      drive(0, 41, 21, 2'b00);
      // outputs: 00:41:20, jump made in set mode
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL set_no_err: got %b want 0", err_pulse); end
      tests++; if (mm_bcd !== 8'h41) begin fails++; $display("FAIL set_mm41: got %h want 41", mm_bcd); end
      drive(0, 41, 22, 2'b00);
      drive(0, 41, 23, 2'b00);
      drive(0, 41, 24, 2'b00);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL set_not_yet: got %b want 0", locked); end
      drive(0, 41, 25, 2'b00);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL set_relock: got %b want 1", locked); end
      tests++; if (err_count !== 8'h02) begin fails++; $display("FAIL set_err_count: got %h want 02", err_count); end
      tests++; if (pulses !== 2) begin fails++; $display("FAIL set_pulse_total: got %0d want 2", pulses); end
   endtask

   task automatic test_watchdog;
      int p0;
      p0 = pulses;
      drive(8, 15, 26, 2'b10);
      drive(8, 15, 27, 2'b00);
      drive(8, 15, 28, 2'b00);
      drive(8, 15, 29, 2'b00);
      drive(8, 15, 30, 2'b00);
      for (int unsigned i = 0; i < 20; i++) drive(8, 15, 30, 2'b00);
      drive(8, 15, 31, 2'b00);
      drive(8, 15, 31, 2'b00);
      tests++; if (pulses - p0 !== WD_ERRS) begin fails++; $display("FAIL wd_pulses: got %0d want %0d", pulses - p0, WD_ERRS); end
      tests++; if (err_count !== 8'(2 + WD_ERRS)) begin fails++; $display("FAIL wd_err_count: got %h want %h", err_count, 8'(2 + WD_ERRS)); end
      tests++; if (mon_state !== 2'b01) begin fails++; $display("FAIL wd_state: got %b want 01", mon_state); end
      tests++; if ({hh_bcd, mm_bcd} !== 16'h0815) begin fails++; $display("FAIL wd_hhmm: got %h want 0815", {hh_bcd, mm_bcd}); end
   endtask

   task automatic test_saturate_and_async_reset;
      for (int unsigned i = 0; i < 10; i++) drive_raw(7'h00, 7'h00, 7'h00, 7'h00, 7'd0, 2'b00);
      // nine invalid samples processed so far
      tests++; if (err_count !== 8'(11 + WD_ERRS)) begin fails++; $display("FAIL sat_partial: got %h want %h", err_count, 8'(11 + WD_ERRS)); end
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL sat_valid: got %b want 0", sample_valid); end
      for (int unsigned i = 0; i < 300; i++) drive_raw(7'h00, 7'h00, 7'h00, 7'h00, 7'd0, 2'b00);
      tests++; if (err_count !== 8'hFF) begin fails++; $display("FAIL sat_count: got %h want ff", err_count); end
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL sat_pulse: got %b want 1", err_pulse); end
      tests++; if (mon_state !== 2'b10) begin fails++; $display("FAIL sat_state: got %b want 10", mon_state); end
      #2;
      rst = 1'b1;
      #1;
      tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL arst_count: got %h want 00", err_count); end
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL arst_pulse: got %b want 0", err_pulse); end
      tests++; if (mon_state !== 2'b00) begin fails++; $display("FAIL arst_state: got %b want 00", mon_state); end
      @(negedge clk);
      rst = 1'b0;
      drive(12, 34, 56, 2'b00);
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL post_rst_latency: got %b want 0", sample_valid); end
      drive(12, 34, 57, 2'b00);
      tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL post_rst_valid: got %b want 1", sample_valid); end
      tests++; if ({hh_bcd, mm_bcd} !== 16'h1234) begin fails++; $display("FAIL post_rst_hhmm: got %h want 1234", {hh_bcd, mm_bcd}); end
      tests++; if (ss_bin !== 7'd56) begin fails++; $display("FAIL post_rst_ss: got %0d want 56", ss_bin); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_wrap_and_jump();
      test_invalid_glyph();
      test_set_mode();
      test_watchdog();
      test_saturate_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
